// File: rtl/hssl_reg_wr_sched_if.sv
// Command handshake from the packet receiver into the register write scheduler.
interface hssl_reg_wr_sched_if;
  logic [7:0]  prx_addr_in;
  logic [31:0] prx_wdata_in;
  logic        prx_vld_in;
  logic        prx_rdy_out;

  modport master (
    output prx_addr_in,
    output prx_wdata_in,
    output prx_vld_in,
    input  prx_rdy_out
  );

  modport slave (
    input  prx_addr_in,
    input  prx_wdata_in,
    input  prx_vld_in,
    output prx_rdy_out
  );
endinterface

// File: rtl/hssl_reg_wr_sched.sv
// Buffers packet register writes and slips them into APB-idle cycles, with a
// bounded-wait guard that forces a write through on a full FIFO or stale head.
module hssl_reg_wr_sched #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_WAIT   = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  hssl_reg_wr_sched_if.slave            prx,
  input  logic                          apb_psel_in,
  output logic [7:0]                    reg_addr_out,
  output logic [31:0]                   reg_wdata_out,
  output logic                          reg_en_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out,
  output logic [15:0]                   force_cnt_out
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [LvlW-1:0] Full     = LvlW'(FIFO_DEPTH);
  localparam logic [15:0]     WaitLast = 16'(MAX_WAIT - 1);

  typedef enum logic [1:0] {StIdle, StReady, StDefer} state_e;

  state_e            state_q, state_d;
  logic [7:0]        addr_mem [FIFO_DEPTH];
  logic [31:0]       data_mem [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]   count_q, count_d;
  logic [15:0]       wait_q, wait_d;
  logic [15:0]       force_q, force_d;
  logic              rdy_q;
  logic              en_q;
  logic [7:0]        addr_q;
  logic [31:0]       wdata_q;
  logic              push, issue, guard;

  assign push  = prx.prx_vld_in & rdy_q;
  assign guard = (wait_q == WaitLast) | (count_q == Full);
  // Only registered occupancy is visible here, so a fresh push never issues in its own cycle.
  assign issue = (state_q != StIdle) & (~apb_psel_in | guard);

  always_comb begin
    count_d = count_q;
    if (push && !issue) begin
      count_d = count_q + LvlW'(1);
    end else if (!push && issue) begin
      count_d = count_q - LvlW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (push) state_d = StReady;
      end
      StReady, StDefer: begin
        if (count_d == '0) begin
          state_d = StIdle;
        end else if (issue) begin
          state_d = StReady;
        end else begin
          state_d = StDefer;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (issue || (count_q == '0)) begin
      wait_d = '0;
    end else if (wait_q != WaitLast) begin
      wait_d = wait_q + 16'd1;
    end
  end

  always_comb begin
    force_d = force_q;
    if (issue && apb_psel_in && (force_q != 16'hffff)) begin
      force_d = force_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wait_q   <= '0;
      force_q  <= '0;
      rdy_q    <= 1'b0;
      en_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wait_q  <= wait_d;
      force_q <= force_d;
      rdy_q   <= (count_d < Full);
      en_q    <= issue;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (issue) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
        addr_q   <= addr_mem[rd_ptr_q];
        wdata_q  <= data_mem[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= prx.prx_addr_in;
      data_mem[wr_ptr_q] <= prx.prx_wdata_in;
    end
  end

  assign prx.prx_rdy_out = rdy_q;
  assign reg_en_out      = en_q;
  assign reg_addr_out    = addr_q;
  assign reg_wdata_out   = wdata_q;
  assign fifo_level_out  = count_q;
  assign force_cnt_out   = force_q;

endmodule

// File: tb/tb_hssl_reg_wr_sched.sv
// Directed vector bench for the register write scheduler (FIFO_DEPTH 4, MAX_WAIT 16).
module tb_hssl_reg_wr_sched;

  logic        clk;
  logic        resetn;
  logic        apb_psel;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_en;
  logic [2:0]  fifo_level;
  logic [15:0] force_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  hssl_reg_wr_sched_if prx_if ();

  hssl_reg_wr_sched #(
    .FIFO_DEPTH (4),
    .MAX_WAIT   (16)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .prx            (prx_if),
    .apb_psel_in    (apb_psel),
    .reg_addr_out   (reg_addr),
    .reg_wdata_out  (reg_wdata),
    .reg_en_out     (reg_en),
    .fifo_level_out (fifo_level),
    .force_cnt_out  (force_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        psel;
    logic        rdy;
    logic        en;
    logic [7:0]  eaddr;
    logic [31:0] ewdata;
    logic [2:0]  lvl;
    logic [15:0] frc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic vld, logic [7:0] a, logic [31:0] d, logic ps, logic rdy,
                              logic en, logic [7:0] ea, logic [31:0] ed, logic [2:0] lv,
                              logic [15:0] f);
    vec_t v;
    v.vld = vld; v.addr = a; v.wdata = d; v.psel = ps; v.rdy = rdy;
    v.en = en; v.eaddr = ea; v.ewdata = ed; v.lvl = lv; v.frc = f;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      prx_if.prx_vld_in   = tbl[i].vld;
      prx_if.prx_addr_in  = tbl[i].addr;
      prx_if.prx_wdata_in = tbl[i].wdata;
      apb_psel            = tbl[i].psel;
      tick();
      chk($sformatf("row%0d rdy", i), 32'(prx_if.prx_rdy_out), 32'(tbl[i].rdy));
      chk($sformatf("row%0d en", i), 32'(reg_en), 32'(tbl[i].en));
      chk($sformatf("row%0d addr", i), 32'(reg_addr), 32'(tbl[i].eaddr));
      chk($sformatf("row%0d wdata", i), reg_wdata, tbl[i].ewdata);
      chk($sformatf("row%0d level", i), 32'(fifo_level), 32'(tbl[i].lvl));
      chk($sformatf("row%0d force", i), 32'(force_cnt), 32'(tbl[i].frc));
    end
  endtask

  initial begin
    int split;
    int first_k;
    int pulses;

    // Single write, APB idle
    tbl.push_back(mk(1, 8'h12, 32'hcafe_0001, 0, 1, 0, 8'h00, 32'h0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 32'h0, 0, 1, 1, 8'h12, 32'hcafe_0001, 0, 0));
    tbl.push_back(mk(0, 8'h00, 32'h0, 0, 1, 0, 8'h12, 32'hcafe_0001, 0, 0));
    // Burst of 6 with a repeated address, APB idle
    tbl.push_back(mk(1, 8'h20, 32'h1000_0000, 0, 1, 0, 8'h12, 32'hcafe_0001, 1, 0));
    tbl.push_back(mk(1, 8'h21, 32'h1000_0001, 0, 1, 1, 8'h20, 32'h1000_0000, 1, 0));
    tbl.push_back(mk(1, 8'h22, 32'h1000_0002, 0, 1, 1, 8'h21, 32'h1000_0001, 1, 0));
    tbl.push_back(mk(1, 8'h22, 32'h1000_0003, 0, 1, 1, 8'h22, 32'h1000_0002, 1, 0));
    tbl.push_back(mk(1, 8'h24, 32'h1000_0004, 0, 1, 1, 8'h22, 32'h1000_0003, 1, 0));
    tbl.push_back(mk(1, 8'h25, 32'h1000_0005, 0, 1, 1, 8'h24, 32'h1000_0004, 1, 0));
    tbl.push_back(mk(0, 8'h00, 32'h0, 0, 1, 1, 8'h25, 32'h1000_0005, 0, 0));
    tbl.push_back(mk(0, 8'h00, 32'h0, 0, 1, 0, 8'h25, 32'h1000_0005, 0, 0));
    // APB busy for 5 cycles with one pending write
    tbl.push_back(mk(1, 8'h33, 32'h3333_0001, 1, 1, 0, 8'h25, 32'h1000_0005, 1, 0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0, 8'h00, 32'h0, 1, 1, 0, 8'h25, 32'h1000_0005, 1, 0));
    tbl.push_back(mk(0, 8'h00, 32'h0, 0, 1, 1, 8'h33, 32'h3333_0001, 0, 0));
    tbl.push_back(mk(0, 8'h00, 32'h0, 0, 1, 0, 8'h33, 32'h3333_0001, 0, 0));
    split = tbl.size();
    // APB busy, 4 pushes fill the FIFO; fifth offer is refused while rdy is low
    tbl.push_back(mk(1, 8'h50, 32'h5555_0000, 1, 1, 0, 8'h44, 32'h4444_0001, 1, 1));
    tbl.push_back(mk(1, 8'h51, 32'h5555_0001, 1, 1, 0, 8'h44, 32'h4444_0001, 2, 1));
    tbl.push_back(mk(1, 8'h52, 32'h5555_0002, 1, 1, 0, 8'h44, 32'h4444_0001, 3, 1));
    tbl.push_back(mk(1, 8'h53, 32'h5555_0003, 1, 0, 0, 8'h44, 32'h4444_0001, 4, 1));
    tbl.push_back(mk(1, 8'h54, 32'h5555_0004, 1, 1, 1, 8'h50, 32'h5555_0000, 3, 2));

    resetn = 1'b0;
    apb_psel = 1'b0;
    prx_if.prx_vld_in = 1'b0;
    prx_if.prx_addr_in = '0;
    prx_if.prx_wdata_in = '0;
    tick();
    tick();
    chk("reset rdy", 32'(prx_if.prx_rdy_out), 32'd0);
    chk("reset en", 32'(reg_en), 32'd0);
    chk("reset addr", 32'(reg_addr), 32'd0);
    chk("reset wdata", reg_wdata, 32'd0);
    chk("reset level", 32'(fifo_level), 32'd0);
    chk("reset force", 32'(force_cnt), 32'd0);
    resetn = 1'b1;
    tick();
    chk("rdy after release", 32'(prx_if.prx_rdy_out), 32'd1);

    run_rows(0, split);

    // APB held busy: head must be forced out exactly 16 edges after it became head
    apb_psel = 1'b1;
    prx_if.prx_vld_in = 1'b1;
    prx_if.prx_addr_in = 8'h44;
    prx_if.prx_wdata_in = 32'h4444_0001;
    tick();
    prx_if.prx_vld_in = 1'b0;
    chk("hold level", 32'(fifo_level), 32'd1);
    first_k = 0;
    pulses = 0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (reg_en) begin
        pulses++;
        if (first_k == 0) first_k = k;
      end
    end
    chk("hold strobe edge", 32'(first_k), 32'd16);
    chk("hold pulse count", 32'(pulses), 32'd1);
    chk("hold addr", 32'(reg_addr), 32'h44);
    chk("hold wdata", reg_wdata, 32'h4444_0001);
    chk("hold force", 32'(force_cnt), 32'd1);

    run_rows(split, tbl.size());

    // Reset mid-flight with 3 queued entries and a strobe currently high
    prx_if.prx_vld_in = 1'b0;
    apb_psel = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk("async en", 32'(reg_en), 32'd0);
    chk("async level", 32'(fifo_level), 32'd0);
    chk("async rdy", 32'(prx_if.prx_rdy_out), 32'd0);
    chk("async addr", 32'(reg_addr), 32'd0);
    chk("async force", 32'(force_cnt), 32'd0);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (reg_en) pulses++;
    end
    resetn = 1'b1;
    chk("rdy before edge", 32'(prx_if.prx_rdy_out), 32'd0);
    tick();
    chk("rdy one edge after", 32'(prx_if.prx_rdy_out), 32'd1);
    chk("level after reset", 32'(fifo_level), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (reg_en) pulses++;
    end
    chk("strobes after reset", 32'(pulses), 32'd0);
    chk("level stays empty", 32'(fifo_level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
